// File: rtl/sevseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Holds the scan state encoding, the dark-digit code and counter sizing.
package sevseg_pkg;

    typedef enum logic [0:0] {
        StBlank,
        StDrive
    } scan_state_e;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Bits needed to hold values 0..max_count-1, never less than one.
    function automatic int unsigned cnt_width(int unsigned max_count);
        return (max_count > 1) ? int'($clog2(max_count)) : 1;
    endfunction

endpackage

// File: rtl/sevseg_scan_ctrl_if.sv
// Load port and display outputs of the scan controller.
// The game logic holds the master side; the controller is the slave.
interface sevseg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_digits;
    logic [NUM_DIGITS-1:0]   load_blank;
    logic [NUM_DIGITS-1:0]   load_blink;
    logic [3:0]              bcd;
    logic [NUM_DIGITS-1:0]   dig_an;
    logic                    frame_done;

    modport master (
        output load_valid, load_digits, load_blank, load_blink,
        input  load_ready, bcd, dig_an, frame_done
    );

    modport slave (
        input  load_valid, load_digits, load_blank, load_blink,
        output load_ready, bcd, dig_an, frame_done
    );
endinterface

// File: rtl/sevseg_slot_timer.sv
// Loadable down-counter timing BLANK and DRIVE phases of a scan slot.
// tc_next_o flags that the count will be at terminal on the next cycle.
module sevseg_slot_timer #(
    parameter int unsigned     Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             tc_o,
    output logic             tc_next_o
);
    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ResetVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o      = (cnt_q == '0);
    assign tc_next_o = (cnt_d == '0);
endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Loads are double-buffered and committed only at frame boundaries.
module sevseg_scan_ctrl
    import sevseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input logic               clk,
    input logic               rst,
    sevseg_scan_ctrl_if.slave bus
);
    localparam int unsigned MaxSlot = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TimerW  = cnt_width(MaxSlot);
    localparam int unsigned IdxW    = cnt_width(NUM_DIGITS);
    localparam int unsigned FrameW  = cnt_width(BLINK_FRAMES);

    localparam logic [TimerW-1:0] BlankLoad = TimerW'(BLANK_CYCLES - 1);
    localparam logic [TimerW-1:0] DwellLoad = TimerW'(DWELL_CYCLES - 1);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NUM_DIGITS - 1);
    localparam logic [FrameW-1:0] LastFrame = FrameW'(BLINK_FRAMES - 1);

    scan_state_e             state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [FrameW-1:0]       frame_q, frame_d;
    logic                    phase_q, phase_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d, pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
    logic                    pending_q, pending_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dig_an_q, dig_an_d;
    logic                    frame_done_q, frame_done_d;
    logic                    timer_load, tc, tc_next, boundary;
    logic [TimerW-1:0]       timer_val;
    logic [NUM_DIGITS-1:0]   dark_q;

    // Reset preloads the blank duration so the first slot after reset is full length.
    sevseg_slot_timer #(
        .Width   (TimerW),
        .ResetVal(BlankLoad)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .tc_o      (tc),
        .tc_next_o (tc_next)
    );

    assign dark_q = act_blank_q | (act_blink_q & {NUM_DIGITS{phase_q}});

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_d       = frame_q;
        phase_d       = phase_q;
        act_digits_d  = act_digits_q;
        act_blank_d   = act_blank_q;
        act_blink_d   = act_blink_q;
        pend_digits_d = pend_digits_q;
        pend_blank_d  = pend_blank_q;
        pend_blink_d  = pend_blink_q;
        pending_d     = pending_q;
        bcd_d         = bcd_q;
        dig_an_d      = dig_an_q;
        timer_load    = 1'b0;
        timer_val     = DwellLoad;
        boundary      = 1'b0;

        unique case (state_q)
            StBlank: begin
                if (tc) begin
                    state_d    = StDrive;
                    timer_load = 1'b1;
                    timer_val  = DwellLoad;
                    dig_an_d   = '1;
                    if (!dark_q[idx_q]) dig_an_d[idx_q] = 1'b0;
                end
            end
            StDrive: begin
                if (tc) begin
                    state_d    = StBlank;
                    timer_load = 1'b1;
                    timer_val  = BlankLoad;
                    dig_an_d   = '1;
                    idx_d      = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                    boundary   = (idx_q == LastIdx);
                end
            end
            default: state_d = StBlank;
        endcase

        if (boundary) begin
            if (pending_q) begin
                act_digits_d = pend_digits_q;
                act_blank_d  = pend_blank_q;
                act_blink_d  = pend_blink_q;
                pending_d    = 1'b0;
            end
            if (frame_q == LastFrame) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end

        if (bus.load_valid && !pending_q) begin
            pend_digits_d = bus.load_digits;
            pend_blank_d  = bus.load_blank;
            pend_blink_d  = bus.load_blink;
            pending_d     = 1'b1;
        end

        // BLANK entry samples post-commit contents so a new frame shows new values at once.
        if (state_q == StDrive && tc) begin
            bcd_d = (act_blank_d[idx_d] | (act_blink_d[idx_d] & phase_d)) ? BCD_BLANK
                  : act_digits_d[{idx_d, 2'b00} +: 4];
        end
    end

    assign frame_done_d = (state_d == StDrive) && (idx_d == LastIdx) && tc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBlank;
            idx_q         <= '0;
            frame_q       <= '0;
            phase_q       <= 1'b0;
            act_digits_q  <= '0;
            act_blank_q   <= '0;
            act_blink_q   <= '0;
            pend_digits_q <= '0;
            pend_blank_q  <= '0;
            pend_blink_q  <= '0;
            pending_q     <= 1'b0;
            bcd_q         <= BCD_BLANK;
            dig_an_q      <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            phase_q       <= phase_d;
            act_digits_q  <= act_digits_d;
            act_blank_q   <= act_blank_d;
            act_blink_q   <= act_blink_d;
            pend_digits_q <= pend_digits_d;
            pend_blank_q  <= pend_blank_d;
            pend_blink_q  <= pend_blink_d;
            pending_q     <= pending_d;
            bcd_q         <= bcd_d;
            dig_an_q      <= dig_an_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.load_ready = ~pending_q;
    assign bus.bcd        = bcd_q;
    assign bus.dig_an     = dig_an_q;
    assign bus.frame_done = frame_done_q;
endmodule
